// File: rtl/adc_moving_avg.sv
// Boxcar moving average over the last 2**LOG2_N signed samples, registered mean output.
// Optional build macro MAVG_CHANGE_STROBE_EN: accept a sample whenever sample_in changes, ignoring sample_valid.
module adc_moving_avg #(
    parameter int DATA_W = 16,
    parameter int LOG2_N = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic [DATA_W-1:0] avg_out,
    output logic              avg_valid,
    output logic              win_full
);
    // Handshake: a sample is taken on any clk edge where accept is high and rst is low;
    // there is no ready, so the source may strobe every cycle. avg_valid is a 1-cycle strobe.
    localparam int N     = 1 << LOG2_N;
    localparam int SUM_W = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] PTR_ONE  = LOG2_N'(1);
    localparam logic [LOG2_N-1:0] CNT_LAST = LOG2_N'(N - 1);

    typedef enum logic {FILL, RUN} state_t;

    logic              accept;
    logic [DATA_W-1:0] accept_data;

`ifdef MAVG_CHANGE_STROBE_EN
    logic [DATA_W-1:0] smp_q;
    logic              chg_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            smp_q <= '0;
            chg_q <= 1'b0;
        end else begin
            smp_q <= sample_in;
            chg_q <= (sample_in != smp_q);
        end
    end

    // The strobe trails the change by one cycle, so the registered copy already holds the new word.
    assign accept      = chg_q;
    assign accept_data = smp_q;
`else
    assign accept      = sample_valid;
    assign accept_data = sample_in;
`endif

    logic [DATA_W-1:0]        ring_mem [N];
    state_t                   state_q,   state_d;
    logic [LOG2_N-1:0]        wr_ptr_q,  wr_ptr_d;
    logic [LOG2_N-1:0]        fill_cnt_q, fill_cnt_d;
    logic signed [SUM_W-1:0]  sum_q,     sum_d;
    logic [DATA_W-1:0]        avg_out_q, avg_out_d;
    logic                     avg_valid_q, avg_valid_d;
    logic                     win_full_q, win_full_d;

    logic [DATA_W-1:0]        oldest;
    logic signed [SUM_W-1:0]  sum_next;

    always_comb begin
        oldest   = (state_q == FILL) ? '0 : ring_mem[wr_ptr_q];
        sum_next = sum_q + SUM_W'($signed(accept_data)) - SUM_W'($signed(oldest));

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        sum_d       = sum_q;
        avg_out_d   = avg_out_q;
        avg_valid_d = 1'b0;
        win_full_d  = win_full_q;

        if (accept) begin
            sum_d    = sum_next;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            case (state_q)
                FILL: begin
                    if (fill_cnt_q == CNT_LAST) begin
                        state_d     = RUN;
                        win_full_d  = 1'b1;
                        avg_valid_d = 1'b1;
                        // Dropping the low bits of a signed sum is an arithmetic shift (floor).
                        avg_out_d   = sum_next[SUM_W-1:LOG2_N];
                    end else begin
                        fill_cnt_d = fill_cnt_q + PTR_ONE;
                    end
                end
                RUN: begin
                    avg_valid_d = 1'b1;
                    avg_out_d   = sum_next[SUM_W-1:LOG2_N];
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            wr_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            sum_q       <= '0;
            avg_out_q   <= '0;
            avg_valid_q <= 1'b0;
            win_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            sum_q       <= sum_d;
            avg_out_q   <= avg_out_d;
            avg_valid_q <= avg_valid_d;
            win_full_q  <= win_full_d;
        end
    end

    // Sample storage is deliberately left uncleared; FILL masks stale contents.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            ring_mem[wr_ptr_q] <= accept_data;
        end
    end

    assign avg_out   = avg_out_q;
    assign avg_valid = avg_valid_q;
    assign win_full  = win_full_q;

endmodule

// File: tb/tb_adc_moving_avg.sv
// Self-checking bench for adc_moving_avg (DATA_W=16, LOG2_N=3), directed tables plus a random run
// against a window-queue reference model.
module tb_adc_moving_avg;
    localparam int N = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic [15:0] avg_out;
    logic        avg_valid;
    logic        win_full;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    int          win_q[$];
    logic [15:0] exp_q[$];

    adc_moving_avg #(.DATA_W(16), .LOG2_N(3)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
        .avg_out(avg_out), .avg_valid(avg_valid), .win_full(win_full)
    );

    always #5 clk = ~clk;

    // Drive for one cycle, then sample outputs 1 time unit after the edge.
    task automatic step(input logic [15:0] v, input logic vld);
        sample_in    = v;
        sample_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(16'd0, 1'b0);
        rst = 1'b0;
        win_q.delete();
        exp_q.delete();
    endtask

    function automatic int floor_div_n(input int s);
        if (s >= 0) return s / N;
        return -((-s + N - 1) / N);
    endfunction

    // Reference: mean of the last N accepted samples, defined once N have been seen.
    function automatic void model_accept(input logic [15:0] v, output logic ev, output logic [15:0] ea);
        int s;
        int q;
        win_q.push_back(int'($signed(v)));
        if (win_q.size() > N) void'(win_q.pop_front());
        s = 0;
        foreach (win_q[k]) s += win_q[k];
        q  = floor_div_n(s);
        ev = (win_q.size() == N);
        ea = q[15:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(16'd777, 1'b1);
        rst = 1'b0;
        chk_cnt++; if (avg_out !== 16'd0) $display("FAIL reset_avg_out got %h want 0000", avg_out); else pass_cnt++;
        chk_cnt++; if (avg_valid !== 1'b0) $display("FAIL reset_avg_valid got %b want 0", avg_valid); else pass_cnt++;
        chk_cnt++; if (win_full !== 1'b0) $display("FAIL reset_win_full got %b want 0", win_full); else pass_cnt++;
        step(16'd0, 1'b0);
        chk_cnt++; if (avg_valid !== 1'b0) $display("FAIL reset_idle_valid got %b want 0", avg_valid); else pass_cnt++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            step(16'd100, 1'b1);
            chk_cnt++; if (avg_valid !== (i == 7)) $display("FAIL fill_valid[%0d] got %b want %b", i, avg_valid, (i == 7)); else pass_cnt++;
            chk_cnt++; if (win_full !== (i == 7)) $display("FAIL fill_win_full[%0d] got %b want %b", i, win_full, (i == 7)); else pass_cnt++;
        end
        chk_cnt++; if (avg_out !== 16'd100) $display("FAIL fill_avg_out got %0d want 100", avg_out); else pass_cnt++;
        step(16'd0, 1'b0);
        chk_cnt++; if (avg_valid !== 1'b0) $display("FAIL fill_pulse_width got %b want 0", avg_valid); else pass_cnt++;
        chk_cnt++; if (avg_out !== 16'd100) $display("FAIL fill_hold got %0d want 100", avg_out); else pass_cnt++;
    endtask

    task automatic test_step();
        logic [15:0] tbl [8];
        tbl = '{16'd112, 16'd125, 16'd137, 16'd150, 16'd162, 16'd175, 16'd187, 16'd200};
        for (int i = 0; i < 8; i++) begin
            step(16'd200, 1'b1);
            chk_cnt++; if (avg_valid !== 1'b1) $display("FAIL step_valid[%0d] got %b want 1", i, avg_valid); else pass_cnt++;
            chk_cnt++; if (avg_out !== tbl[i]) $display("FAIL step_avg[%0d] got %0d want %0d", i, avg_out, tbl[i]); else pass_cnt++;
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < 8; i++) step(16'hFFF8, 1'b1);
        chk_cnt++; if (avg_out !== 16'hFFF8) $display("FAIL neg_avg got %h want fff8", avg_out); else pass_cnt++;
        step(16'hFFF3, 1'b1);
        chk_cnt++; if (avg_out !== 16'hFFF7) $display("FAIL neg_floor got %h want fff7", avg_out); else pass_cnt++;
        chk_cnt++; if (win_full !== 1'b1) $display("FAIL neg_win_full got %b want 1", win_full); else pass_cnt++;
    endtask

    task automatic test_reset_mid_fill();
        do_reset();
        for (int i = 0; i < 5; i++) step(16'd50, 1'b1);
        rst = 1'b1;
        step(16'd99, 1'b1);
        rst = 1'b0;
        chk_cnt++; if (win_full !== 1'b0 || avg_out !== 16'd0) $display("FAIL midfill_reset got full=%b avg=%0d want 0/0", win_full, avg_out); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            step(16'd10, 1'b1);
            chk_cnt++; if (avg_valid !== (i == 7)) $display("FAIL midfill_valid[%0d] got %b want %b", i, avg_valid, (i == 7)); else pass_cnt++;
            step(16'd0, 1'b0);
            chk_cnt++; if (avg_valid !== 1'b0) $display("FAIL midfill_gap[%0d] got %b want 0", i, avg_valid); else pass_cnt++;
        end
        chk_cnt++; if (avg_out !== 16'd10) $display("FAIL midfill_avg got %0d want 10", avg_out); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        do_reset();
        pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(16'(i), 1'b1);
            if (avg_valid === 1'b1) pulses++;
            chk_cnt++; if (avg_valid !== (i >= 7)) $display("FAIL b2b_valid[%0d] got %b want %b", i, avg_valid, (i >= 7)); else pass_cnt++;
            if (i >= 7) begin
                chk_cnt++; if (avg_out !== 16'(i - 4)) $display("FAIL b2b_avg[%0d] got %0d want %0d", i, avg_out, i - 4); else pass_cnt++;
            end
        end
        step(16'd0, 1'b0);
        chk_cnt++; if (pulses != 9 || avg_valid !== 1'b0) $display("FAIL b2b_pulses got %0d valid=%b want 9/0", pulses, avg_valid); else pass_cnt++;
    endtask

    task automatic test_random();
        logic        ev;
        logic        vld;
        logic [15:0] ea;
        logic [15:0] v;
        logic [15:0] got;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0:       v = 16'h8000;
                1:       v = 16'h7FFF;
                default: v = 16'($urandom);
            endcase
            if ($urandom_range(0, 60) == 0) begin
                rst = 1'b1;
                step(v, vld);
                rst = 1'b0;
                win_q.delete();
                chk_cnt++; if (avg_valid !== 1'b0 || win_full !== 1'b0 || avg_out !== 16'd0)
                    $display("FAIL rand_reset[%0d] got v=%b f=%b a=%h want 0/0/0000", i, avg_valid, win_full, avg_out); else pass_cnt++;
                if (exp_q.size() != 0) exp_q.delete();
            end else begin
                ev = 1'b0;
                ea = 16'd0;
                if (vld) model_accept(v, ev, ea);
                if (ev) exp_q.push_back(ea);
                step(v, vld);
                chk_cnt++; if (avg_valid !== ev) $display("FAIL rand_valid[%0d] got %b want %b", i, avg_valid, ev); else pass_cnt++;
                chk_cnt++; if (win_full !== (win_q.size() == N)) $display("FAIL rand_full[%0d] got %b want %b", i, win_full, (win_q.size() == N)); else pass_cnt++;
                if (avg_valid === 1'b1 && exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    chk_cnt++; if (avg_out !== got) $display("FAIL rand_avg[%0d] got %h want %h", i, avg_out, got); else pass_cnt++;
                end
            end
        end
    endtask

    task automatic test_change_strobe();
        logic [15:0] vals [8];
        logic        ev;
        logic [15:0] ea;
        int          pulses;
        vals = '{16'h1234, 16'h1240, 16'd1000, 16'd2000, 16'd3000, 16'd4000, 16'd5000, 16'd6000};
        do_reset();
        for (int s = 0; s < 8; s++) begin
            model_accept(vals[s], ev, ea);
            pulses = 0;
            for (int c = 0; c < ((s == 0) ? 40 : 6); c++) begin
                step(vals[s], 1'b0);
                if (avg_valid === 1'b1) pulses++;
            end
            chk_cnt++; if (pulses != (s == 7 ? 1 : 0)) $display("FAIL chg_pulses[%0d] got %0d want %0d", s, pulses, (s == 7 ? 1 : 0)); else pass_cnt++;
            chk_cnt++; if (win_full !== (s == 7)) $display("FAIL chg_full[%0d] got %b want %b", s, win_full, (s == 7)); else pass_cnt++;
        end
        chk_cnt++; if (avg_out !== ea) $display("FAIL chg_avg got %h want %h", avg_out, ea); else pass_cnt++;
    endtask

    initial begin
        rst          = 1'b0;
        sample_in    = 16'd0;
        sample_valid = 1'b0;
        @(negedge clk);
        test_reset();
`ifdef MAVG_CHANGE_STROBE_EN
        test_change_strobe();
`else
        test_fill();
        test_step();
        test_negative();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
